// File: rtl/pipelined_lsu_pkg.sv
// Shared definitions for the pipelined load/store unit: widths, op codes,
// FSM state encoding and small op classification helpers.
package pipelined_lsu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int OFF_W  = 2;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_LOAD_RD     = 2'd1,
        ST_STORE_MERGE = 2'd2
    } lsu_state_e;

    function automatic logic isMisaligned(input lsu_op_e op, input logic [OFF_W-1:0] off);
        logic mis;
        case (op)
            OP_LW, OP_SW:         mis = (off != '0);
            OP_LH, OP_LHU, OP_SH: mis = off[0];
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic isLoad(input lsu_op_e op);
        return (op != OP_SW) && (op != OP_SH) && (op != OP_SB);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane logic: extracts and extends a load lane from a memory word,
// and merges a store byte/halfword into a memory word.
module lsu_lane_align
    import pipelined_lsu_pkg::*;
(
    input  lsu_op_e           i_op,
    input  logic [OFF_W-1:0]  i_offset,
    input  logic [DATA_W-1:0] i_memData,
    input  logic [15:0]       i_storeLow,
    output logic [DATA_W-1:0] o_loadData,
    output logic [DATA_W-1:0] o_mergeData
);

    // Offset 0 is the most significant byte, so the shift is (3 - offset) * 8.
    logic [4:0]        w_byteShift;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_byteMask;
    logic [DATA_W-1:0] w_byteIns;

    assign w_byteShift = {~i_offset, 3'b000};
    assign w_byte      = 8'(i_memData >> w_byteShift);
    assign w_half      = i_offset[1] ? i_memData[15:0] : i_memData[31:16];
    assign w_byteMask  = 32'h0000_00FF << w_byteShift;
    assign w_byteIns   = {24'h0, i_storeLow[7:0]} << w_byteShift;

    always_comb begin
        o_loadData = '0;
        case (i_op)
            OP_LW:   o_loadData = i_memData;
            OP_LH:   o_loadData = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_loadData = {16'h0, w_half};
            OP_LB:   o_loadData = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_loadData = {24'h0, w_byte};
            default: o_loadData = '0;
        endcase
    end

    always_comb begin
        o_mergeData = i_memData;
        case (i_op)
            OP_SB:   o_mergeData = (i_memData & ~w_byteMask) | w_byteIns;
            OP_SH:   o_mergeData = i_offset[1] ? {i_memData[31:16], i_storeLow}
                                               : {i_storeLow, i_memData[15:0]};
            default: o_mergeData = i_memData;
        endcase
    end

endmodule

// File: rtl/pipelined_load_store_unit.sv
// MEM-stage load/store unit: two-cycle loads and read-modify-write sub-word
// stores against a word memory; aligned word stores complete in one cycle.
module pipelined_load_store_unit
    import pipelined_lsu_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ReqValid,
    input  logic [2:0]        ReqOp,
    input  logic [ADDR_W-1:0] ReqAddress,
    input  logic [DATA_W-1:0] ReqStoreData,
    output logic              Stall,
    output logic              LoadValid,
    output logic [DATA_W-1:0] LoadData,
    output logic              Misaligned,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemoryRead,
    output logic              MemoryWrite,
    input  logic [DATA_W-1:0] MemReadData
);

    lsu_state_e        r_state;
    lsu_state_e        w_nextState;
    lsu_op_e           r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_storeLow;
    logic              r_loadValid;
    logic [DATA_W-1:0] r_loadData;
    logic              r_misaligned;

    lsu_op_e           w_reqOp;
    logic              w_reqMis;
    logic              w_capture;
    logic [DATA_W-1:0] w_extract;
    logic [DATA_W-1:0] w_mergeData;

    assign w_reqOp  = lsu_op_e'(ReqOp);
    assign w_reqMis = isMisaligned(w_reqOp, ReqAddress[OFF_W-1:0]);

    lsu_lane_align u_laneAlign (
        .i_op        (r_op),
        .i_offset    (r_addr[OFF_W-1:0]),
        .i_memData   (MemReadData),
        .i_storeLow  (r_storeLow),
        .o_loadData  (w_extract),
        .o_mergeData (w_mergeData)
    );

    // Strobes are gated by Reset so an in-flight access dies the instant Reset rises.
    always_comb begin
        w_nextState  = r_state;
        w_capture    = 1'b0;
        Stall        = 1'b0;
        MemoryRead   = 1'b0;
        MemoryWrite  = 1'b0;
        MemAddress   = '0;
        MemWriteData = '0;
        if (!Reset) begin
            case (r_state)
                ST_IDLE: begin
                    if (ReqValid && !w_reqMis) begin
                        MemAddress = ReqAddress;
                        if (w_reqOp == OP_SW) begin
                            MemoryWrite  = 1'b1;
                            MemWriteData = ReqStoreData;
                        end else begin
                            MemoryRead  = 1'b1;
                            Stall       = 1'b1;
                            w_capture   = 1'b1;
                            w_nextState = isLoad(w_reqOp) ? ST_LOAD_RD : ST_STORE_MERGE;
                        end
                    end
                end
                ST_LOAD_RD: begin
                    w_nextState = ST_IDLE;
                end
                ST_STORE_MERGE: begin
                    MemoryWrite  = 1'b1;
                    MemAddress   = r_addr;
                    MemWriteData = w_mergeData;
                    w_nextState  = ST_IDLE;
                end
                default: begin
                    w_nextState = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_LW;
            r_addr       <= '0;
            r_storeLow   <= '0;
            r_loadValid  <= 1'b0;
            r_loadData   <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_loadValid  <= (r_state == ST_LOAD_RD);
            r_misaligned <= (r_state == ST_IDLE) && ReqValid && w_reqMis;
            if (w_capture) begin
                r_op       <= w_reqOp;
                r_addr     <= ReqAddress;
                r_storeLow <= ReqStoreData[15:0];
            end
            if (r_state == ST_LOAD_RD) begin
                r_loadData <= w_extract;
            end
        end
    end

    assign LoadValid  = r_loadValid;
    assign LoadData   = r_loadData;
    assign Misaligned = r_misaligned;

endmodule

// File: tb/tb_pipelined_load_store_unit.sv
// Directed self-checking bench for pipelined_load_store_unit with a small
// word-memory model (posedge registered read, negedge write).
`timescale 1ns/100ps
module tb_pipelined_load_store_unit;
    import pipelined_lsu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic [2:0]  ReqOp;
    logic [31:0] ReqAddress;
    logic [31:0] ReqStoreData;
    logic        Stall;
    logic        LoadValid;
    logic [31:0] LoadData;
    logic        Misaligned;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemoryRead;
    logic        MemoryWrite;
    logic [31:0] MemReadData;

    logic [31:0] mem [0:63];
    logic        preload;
    int          errors = 0;
    int          checks = 0;

    pipelined_load_store_unit dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .ReqValid     (ReqValid),
        .ReqOp        (ReqOp),
        .ReqAddress   (ReqAddress),
        .ReqStoreData (ReqStoreData),
        .Stall        (Stall),
        .LoadValid    (LoadValid),
        .LoadData     (LoadData),
        .Misaligned   (Misaligned),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemoryRead   (MemoryRead),
        .MemoryWrite  (MemoryWrite),
        .MemReadData  (MemReadData)
    );

    always #5 Clock = ~Clock;

    // Word memory: the preload pulse seeds word 0x10 before traffic starts.
    always @(posedge Clock) begin
        if (MemoryRead) MemReadData <= mem[MemAddress[7:2]];
    end

    always @(negedge Clock) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8899_AABB;
        end else if (MemoryWrite) begin
            mem[MemAddress[7:2]] <= MemWriteData;
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic v, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] d);
        @(posedge Clock);
        #1;
        ReqValid     = v;
        ReqOp        = op;
        ReqAddress   = a;
        ReqStoreData = d;
        #3;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Three-cycle load: accept with stall, LOAD_RD, then the LoadValid pulse.
    task automatic doLoad(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] expected);
        applyStimulus(1'b1, op, a, 32'h0);
        checkOutput({tag, "_stallA"}, {31'h0, Stall}, 32'h1);
        checkOutput({tag, "_readA"}, {31'h0, MemoryRead}, 32'h1);
        checkOutput({tag, "_addrA"}, MemAddress, a);
        applyStimulus(1'b1, op, a, 32'h0);
        checkOutput({tag, "_stallB"}, {31'h0, Stall}, 32'h0);
        checkOutput({tag, "_readB"}, {31'h0, MemoryRead}, 32'h0);
        checkOutput({tag, "_addrB"}, MemAddress, 32'h0);
        applyStimulus(1'b0, OP_LW, 32'h0, 32'h0);
        checkOutput({tag, "_valid"}, {31'h0, LoadValid}, 32'h1);
        checkOutput({tag, "_data"}, LoadData, expected);
    endtask

    initial begin
        preload      = 1'b1;
        Reset        = 1'b0;
        ReqValid     = 1'b0;
        ReqOp        = OP_LW;
        ReqAddress   = 32'h0;
        ReqStoreData = 32'h0;
        #1 Reset = 1'b1;

        // Reset holds strobes low even with a valid request pending
        applyStimulus(1'b1, OP_LW, 32'h10, 32'h0);
        checkOutput("rst_stall", {31'h0, Stall}, 32'h0);
        checkOutput("rst_read", {31'h0, MemoryRead}, 32'h0);
        checkOutput("rst_write", {31'h0, MemoryWrite}, 32'h0);
        checkOutput("rst_valid", {31'h0, LoadValid}, 32'h0);
        checkOutput("rst_data", LoadData, 32'h0);
        checkOutput("rst_mis", {31'h0, Misaligned}, 32'h0);
        checkOutput("rst_addr", MemAddress, 32'h0);
        applyStimulus(1'b0, OP_LW, 32'h0, 32'h0);
        preload = 1'b0;
        Reset   = 1'b0;
        applyStimulus(1'b0, OP_LW, 32'h0, 32'h0);
        checkOutput("idle_stall", {31'h0, Stall}, 32'h0);
        checkOutput("idle_read", {31'h0, MemoryRead}, 32'h0);

        // Sub-word loads with sign/zero extension
        doLoad("lb11", OP_LB, 32'h11, 32'hFFFF_FF99);
        applyStimulus(1'b0, OP_LW, 32'h0, 32'h0);
        checkOutput("lb11_pulse_end", {31'h0, LoadValid}, 32'h0);
        doLoad("lhu12", OP_LHU, 32'h12, 32'h0000_AABB);
        doLoad("lh10", OP_LH, 32'h10, 32'hFFFF_8899);
        doLoad("lbu10", OP_LBU, 32'h10, 32'h0000_0088);

        // SB read-modify-write; the live store data in cycle B must be ignored
        applyStimulus(1'b1, OP_SB, 32'h13, 32'h0000_00CC);
        checkOutput("sb_readA", {31'h0, MemoryRead}, 32'h1);
        checkOutput("sb_writeA", {31'h0, MemoryWrite}, 32'h0);
        checkOutput("sb_stallA", {31'h0, Stall}, 32'h1);
        applyStimulus(1'b1, OP_SB, 32'h13, 32'hFFFF_FF11);
        checkOutput("sb_readB", {31'h0, MemoryRead}, 32'h0);
        checkOutput("sb_writeB", {31'h0, MemoryWrite}, 32'h1);
        checkOutput("sb_stallB", {31'h0, Stall}, 32'h0);
        checkOutput("sb_addrB", MemAddress, 32'h13);
        checkOutput("sb_wdataB", MemWriteData, 32'h8899_AACC);
        applyStimulus(1'b0, OP_LW, 32'h0, 32'h0);
        checkOutput("sb_writeC", {31'h0, MemoryWrite}, 32'h0);
        checkOutput("sb_wdataC", MemWriteData, 32'h0);
        doLoad("lw10_after_sb", OP_LW, 32'h10, 32'h8899_AACC);

        // Single-cycle aligned SW, then a misaligned SW to the same word
        applyStimulus(1'b1, OP_SW, 32'h14, 32'h1234_5678);
        checkOutput("sw_write", {31'h0, MemoryWrite}, 32'h1);
        checkOutput("sw_read", {31'h0, MemoryRead}, 32'h0);
        checkOutput("sw_stall", {31'h0, Stall}, 32'h0);
        checkOutput("sw_addr", MemAddress, 32'h14);
        checkOutput("sw_wdata", MemWriteData, 32'h1234_5678);
        applyStimulus(1'b1, OP_SW, 32'h15, 32'hDEAD_BEEF);
        checkOutput("swmis_write", {31'h0, MemoryWrite}, 32'h0);
        checkOutput("swmis_stall", {31'h0, Stall}, 32'h0);
        checkOutput("swmis_early", {31'h0, Misaligned}, 32'h0);
        applyStimulus(1'b1, OP_LHU, 32'h11, 32'h0);
        checkOutput("swmis_pulse", {31'h0, Misaligned}, 32'h1);
        checkOutput("lhumis_read", {31'h0, MemoryRead}, 32'h0);
        checkOutput("lhumis_stall", {31'h0, Stall}, 32'h0);
        applyStimulus(1'b0, OP_LW, 32'h0, 32'h0);
        checkOutput("lhumis_pulse", {31'h0, Misaligned}, 32'h1);
        applyStimulus(1'b0, OP_LW, 32'h0, 32'h0);
        checkOutput("mis_clear", {31'h0, Misaligned}, 32'h0);

        // SH into the low half of word 0x14
        applyStimulus(1'b1, OP_SH, 32'h16, 32'h0000_BEEF);
        checkOutput("sh_stallA", {31'h0, Stall}, 32'h1);
        applyStimulus(1'b1, OP_SH, 32'h16, 32'h0000_BEEF);
        checkOutput("sh_wdataB", MemWriteData, 32'h1234_BEEF);
        applyStimulus(1'b0, OP_LW, 32'h0, 32'h0);

        // Back-to-back loads with ReqValid held throughout
        applyStimulus(1'b1, OP_LW, 32'h10, 32'h0);
        checkOutput("b2b_stall1", {31'h0, Stall}, 32'h1);
        applyStimulus(1'b1, OP_LW, 32'h10, 32'h0);
        checkOutput("b2b_rd1", {31'h0, Stall}, 32'h0);
        applyStimulus(1'b1, OP_LW, 32'h14, 32'h0);
        checkOutput("b2b_valid1", {31'h0, LoadValid}, 32'h1);
        checkOutput("b2b_data1", LoadData, 32'h8899_AACC);
        checkOutput("b2b_stall2", {31'h0, Stall}, 32'h1);
        applyStimulus(1'b1, OP_LW, 32'h14, 32'h0);
        checkOutput("b2b_gap", {31'h0, LoadValid}, 32'h0);
        applyStimulus(1'b0, OP_LW, 32'h0, 32'h0);
        checkOutput("b2b_valid2", {31'h0, LoadValid}, 32'h1);
        checkOutput("b2b_data2", LoadData, 32'h1234_BEEF);

        // Reset mid LOAD_RD aborts the load
        applyStimulus(1'b1, OP_LW, 32'h10, 32'h0);
        applyStimulus(1'b1, OP_LW, 32'h10, 32'h0);
        Reset = 1'b1;
        #0.5;
        checkOutput("abort_read", {31'h0, MemoryRead}, 32'h0);
        checkOutput("abort_write", {31'h0, MemoryWrite}, 32'h0);
        checkOutput("abort_stall", {31'h0, Stall}, 32'h0);
        checkOutput("abort_data", LoadData, 32'h0);
        applyStimulus(1'b1, OP_LW, 32'h10, 32'h0);
        checkOutput("abort_novalid", {31'h0, LoadValid}, 32'h0);
        Reset = 1'b0;
        applyStimulus(1'b0, OP_LW, 32'h0, 32'h0);
        checkOutput("abort_novalid2", {31'h0, LoadValid}, 32'h0);
        doLoad("post_rst_lw14", OP_LW, 32'h14, 32'h1234_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_load_store_unit.md
PIPELINED_LOAD_STORE_UNIT -- requirements
Module: pipelined_load_store_unit

Interface
REQ-001 SHALL have ports: Clock  in  1  sole clock; all state on posedge.
REQ-002 SHALL have Reset  in  1  asynchronous, active-high.
REQ-003 SHALL have ReqValid  in  1  MEM-stage request present this cycle.
REQ-004 SHALL have ReqOp  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-005 SHALL have ReqAddress  in  32  byte address; ReqStoreData  in  32  store data, right-justified.
REQ-006 SHALL have Stall  out  1  request not consumed this cycle; the pipeline holds its MEM stage.
REQ-007 SHALL have LoadValid  out  1; LoadData  out  32; Misaligned  out  1.
REQ-008 SHALL have MemAddress  out  32; MemWriteData  out  32; MemoryRead  out  1; MemoryWrite  out  1.
REQ-009 SHALL have MemReadData  in  32, from a word memory that registers the read on posedge when MemoryRead=1, writes on negedge when MemoryWrite=1, and indexes by Address[7:2].

Function
REQ-010 SHALL implement states IDLE, LOAD_RD and STORE_MERGE; the reset state is IDLE.
REQ-011 IDLE, no ReqValid: MemoryRead=0, MemoryWrite=0, Stall=0.
REQ-012 IDLE, ReqValid, misaligned request (LW/SW with Address[1:0]!=0; LH/LHU/SH with Address[0]=1): no memory strobe, Stall=0, Misaligned=1 for one cycle in the next cycle.
REQ-013 IDLE, aligned SW: MemoryWrite=1, MemAddress=ReqAddress, MemWriteData=ReqStoreData in the same cycle; Stall=0; state stays IDLE.
REQ-014 IDLE, aligned load or SH/SB: MemoryRead=1, MemAddress=ReqAddress, Stall=1.
  - Op, address and store data SHALL be captured into internal registers.
  - Next state SHALL be LOAD_RD for loads and STORE_MERGE for SH/SB.
REQ-015 LOAD_RD: memory strobes 0, Stall=0.
  - On the cycle's ending posedge, LoadData SHALL register the extracted, extended lane of MemReadData and LoadValid SHALL pulse 1 for one cycle.
  - Next state SHALL be IDLE.
REQ-016 STORE_MERGE: MemoryWrite=1, MemAddress=captured address, Stall=0.
  - MemWriteData SHALL be MemReadData with the addressed lane replaced by the low 8/16 bits of the captured store data.
  - Next state SHALL be IDLE.
REQ-017 Byte order SHALL be big-endian: offset 0 maps to bits 31:24, offset 3 to bits 7:0; halfword offset 0 maps to 31:16, offset 2 to 15:0.
REQ-018 LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL pass the full word.
REQ-019 Load latency SHALL be 2 cycles from acceptance in IDLE to LoadValid high; a new request SHALL be accepted in the cycle after LOAD_RD or STORE_MERGE, giving back-to-back throughput of 1 access per 2 cycles.
REQ-020 In LOAD_RD/STORE_MERGE, live Req* inputs SHALL be ignored; only captured values are used.
REQ-021 MemAddress and MemWriteData SHALL be 0 when no strobe is active.

Reset
REQ-022 On Reset high, asynchronously: state=IDLE, LoadValid=0, LoadData=0, Misaligned=0, and all captured registers=0.
REQ-023 While Reset is high, MemoryRead, MemoryWrite and Stall SHALL be forced to 0 regardless of ReqValid.
REQ-024 Reset during LOAD_RD or STORE_MERGE SHALL abort the access: no LoadValid, and no MemoryWrite after Reset asserts.

Structure
REQ-025 Op encodings, state encoding and the width constants (32-bit data, 2-bit byte offset) SHALL reside in the shared package pipelined_lsu_pkg.
REQ-026 Lane extract/extend and lane merge SHALL be one combinational sub-module, lsu_lane_align; the FSM and registers SHALL stay in the top level.

Verification
REQ-027 Preload word 0x10=0x8899AABB; LB 0x11 -> Stall 1 cycle, LoadValid 2 cycles later, LoadData=0xFFFFFF99.
REQ-028 LHU 0x12 -> LoadData=0x0000AABB; LH 0x10 -> LoadData=0xFFFF8899.
REQ-029 SB 0x13 with data 0x000000CC -> MemoryRead in cycle A, MemoryWrite only in cycle B with MemWriteData=0x8899AACC; a subsequent LW 0x10 returns 0x8899AACC.
REQ-030 SW 0x14 with 0x12345678 -> single-cycle MemoryWrite, Stall=0; then SW 0x15 -> Misaligned pulse and no MemoryWrite.
REQ-031 Back-to-back LW 0x10 and LW 0x14, ReqValid held -> two LoadValid pulses 2 cycles apart with the correct words.
REQ-032 Reset asserted mid-cycle in LOAD_RD -> MemoryRead/MemoryWrite/Stall drop immediately, LoadValid never pulses, and the FSM is in IDLE after release.
